// File: rtl/learn_costs_pkg.sv
// Shared types and default memory map for the neighbour cost-learning engine.
package learn_costs_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_RD_NCNT,
    ST_RD_KCNT,
    ST_SEARCH,
    ST_UPD_BATT,
    ST_UPD_RDQ,
    ST_UPD_WRQ,
    ST_UPD_CID,
    ST_INS_CHK,
    ST_INS_NID,
    ST_INS_BATT,
    ST_INS_QVAL,
    ST_INS_CID,
    ST_SC_RD,
    ST_SC_WR,
    ST_SC_CNT,
    ST_POST,
    ST_FIN
  } lc_state_e;

  typedef enum logic [1:0] {
    STAT_UPDATED  = 2'd0,
    STAT_INSERTED = 2'd1,
    STAT_FULL     = 2'd2
  } lc_status_e;

  localparam logic [15:0] DEF_EPS_ADDR    = 16'h004;
  localparam logic [15:0] DEF_KSINK_BASE  = 16'h008;
  localparam logic [15:0] DEF_NID_BASE    = 16'h048;
  localparam logic [15:0] DEF_CID_BASE    = 16'h0C8;
  localparam logic [15:0] DEF_BATT_BASE   = 16'h148;
  localparam logic [15:0] DEF_QVAL_BASE   = 16'h1C8;
  localparam logic [15:0] DEF_SID_BASE    = 16'h248;
  localparam logic [15:0] DEF_KSCNT_ADDR  = 16'h688;
  localparam logic [15:0] DEF_NCNT_ADDR   = 16'h68A;
  localparam logic [15:0] DEF_SIDCNT_BASE = 16'h68E;

  // Counts read from memory may exceed what the table can hold.
  function automatic int unsigned clamp_u(int unsigned v, int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/learn_costs_param_if.sv
// Frame-parser / node-RAM signals of the cost-learning engine.
// Handshake: en is a start request seen only while idle; busy covers the whole
// operation, done pulses once at the end and status is valid from done on.
interface learn_costs_param_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic                      en;
  logic [DW-1:0]             fsourceID;
  logic [DW-1:0]             fbatteryStat;
  logic [DW-1:0]             fValue;
  logic [DW-1:0]             fclusterID;
  logic [DW-1:0]             initial_epsilon;
  logic [DW-1:0]             data_in;
  logic [AW-1:0]             address;
  logic [DW-1:0]             data_out;
  logic                      wr_en;
  logic                      busy;
  logic                      done;
  logic [1:0]                status;
  learn_costs_pkg::lc_state_e state_dbg;

  modport slave (
    input  en, fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon, data_in,
    output address, data_out, wr_en, busy, done, status, state_dbg
  );

  modport master (
    output en, fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon, data_in,
    input  address, data_out, wr_en, busy, done, status, state_dbg
  );
endinterface

// File: rtl/mem_seq_port.sv
// Memory port sequencer: registers address/write data, emits one-cycle write
// strobes and flags the CAPTURE cycle that follows each read ADDR cycle.
module mem_seq_port #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_req_i,
  input  logic          wr_req_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] data_in_i,
  output logic [AW-1:0] address_o,
  output logic [DW-1:0] data_out_o,
  output logic          wr_en_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o
);

  logic [AW-1:0] address_q;
  logic [DW-1:0] data_out_q;
  logic          wr_en_q;
  logic          addr_ph_q;
  logic          cap_ph_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      address_q  <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      addr_ph_q  <= 1'b0;
      cap_ph_q   <= 1'b0;
    end else begin
      if (rd_req_i || wr_req_i) address_q <= addr_i;
      if (wr_req_i) data_out_q <= wdata_i;
      wr_en_q   <= wr_req_i;
      addr_ph_q <= rd_req_i;
      // RAM answers one cycle after it sees the address.
      cap_ph_q  <= addr_ph_q;
    end
  end

  assign address_o  = address_q;
  assign data_out_o = data_out_q;
  assign wr_en_o    = wr_en_q;
  assign rd_valid_o = cap_ph_q;
  assign rd_data_o  = data_in_i;

endmodule

// File: rtl/learn_costs_param.sv
// Cost-learning engine: on each routing frame, update or insert the sender's
// neighbour row (ID, cluster, battery, Q-value, sink list) in node RAM.
module learn_costs_param
  import learn_costs_pkg::*;
#(
  parameter int DW            = 16,
  parameter int AW            = 16,
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_SINKS     = 8,
  parameter logic [AW-1:0] EPS_ADDR    = AW'(DEF_EPS_ADDR),
  parameter logic [AW-1:0] KSINK_BASE  = AW'(DEF_KSINK_BASE),
  parameter logic [AW-1:0] NID_BASE    = AW'(DEF_NID_BASE),
  parameter logic [AW-1:0] CID_BASE    = AW'(DEF_CID_BASE),
  parameter logic [AW-1:0] BATT_BASE   = AW'(DEF_BATT_BASE),
  parameter logic [AW-1:0] QVAL_BASE   = AW'(DEF_QVAL_BASE),
  parameter logic [AW-1:0] SID_BASE    = AW'(DEF_SID_BASE),
  parameter logic [AW-1:0] KSCNT_ADDR  = AW'(DEF_KSCNT_ADDR),
  parameter logic [AW-1:0] NCNT_ADDR   = AW'(DEF_NCNT_ADDR),
  parameter logic [AW-1:0] SIDCNT_BASE = AW'(DEF_SIDCNT_BASE)
) (
  input logic                clock,
  input logic                nrst,
  learn_costs_param_if.slave bus
);

  localparam int NCW       = $clog2(MAX_NEIGHBORS + 1);
  localparam int KCW       = $clog2(MAX_SINKS + 1);
  localparam int ROW_BYTES = 2 * MAX_SINKS;

  lc_state_e     state_q;
  lc_status_e    status_q;
  logic          busy_q;
  logic          done_q;
  logic          wait_q;
  logic          found_q;
  logic          reinit_q;
  logic [NCW-1:0] ncnt_q;
  logic [NCW-1:0] n_q;
  logic [KCW-1:0] kcnt_q;
  logic [KCW-1:0] k_q;
  logic [AW-1:0]  row_off_q;
  logic [DW-1:0]  sink_q;

  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  function automatic logic [AW-1:0] word_at(logic [AW-1:0] base, int unsigned idx);
    return base + AW'(idx << 1);
  endfunction

  // Memory request decode; a read is issued once, then the state waits for CAPTURE.
  always_comb begin
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      ST_RD_NCNT: begin
        rd_req   = !wait_q;
        req_addr = NCNT_ADDR;
      end
      ST_RD_KCNT: begin
        rd_req   = !wait_q;
        req_addr = KSCNT_ADDR;
      end
      ST_SEARCH: begin
        rd_req   = !wait_q;
        req_addr = word_at(NID_BASE, 32'(n_q));
      end
      ST_UPD_BATT, ST_INS_BATT: begin
        wr_req    = 1'b1;
        req_addr  = word_at(BATT_BASE, 32'(n_q));
        req_wdata = bus.fbatteryStat;
      end
      ST_UPD_RDQ: begin
        rd_req   = !wait_q;
        req_addr = word_at(QVAL_BASE, 32'(n_q));
      end
      ST_UPD_WRQ, ST_INS_QVAL: begin
        wr_req    = 1'b1;
        req_addr  = word_at(QVAL_BASE, 32'(n_q));
        req_wdata = bus.fValue;
      end
      ST_UPD_CID, ST_INS_CID: begin
        wr_req    = 1'b1;
        req_addr  = word_at(CID_BASE, 32'(n_q));
        req_wdata = bus.fclusterID;
      end
      ST_INS_NID: begin
        wr_req    = 1'b1;
        req_addr  = word_at(NID_BASE, 32'(n_q));
        req_wdata = bus.fsourceID;
      end
      ST_SC_RD: begin
        rd_req   = !wait_q;
        req_addr = word_at(KSINK_BASE, 32'(k_q));
      end
      ST_SC_WR: begin
        wr_req    = 1'b1;
        req_addr  = word_at(SID_BASE + row_off_q, 32'(k_q));
        req_wdata = sink_q;
      end
      ST_SC_CNT: begin
        wr_req    = 1'b1;
        req_addr  = word_at(SIDCNT_BASE, 32'(n_q));
        req_wdata = DW'(kcnt_q);
      end
      ST_POST: begin
        if (!found_q) begin
          wr_req    = 1'b1;
          req_addr  = NCNT_ADDR;
          req_wdata = DW'(ncnt_q) + DW'(1);
        end else if (reinit_q) begin
          wr_req    = 1'b1;
          req_addr  = EPS_ADDR;
          req_wdata = bus.initial_epsilon;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      status_q  <= STAT_UPDATED;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wait_q    <= 1'b0;
      found_q   <= 1'b0;
      reinit_q  <= 1'b0;
      ncnt_q    <= '0;
      n_q       <= '0;
      kcnt_q    <= '0;
      k_q       <= '0;
      row_off_q <= '0;
      sink_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (rd_req) wait_q <= 1'b1;
      else if (rd_valid) wait_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.en) begin
            busy_q   <= 1'b1;
            n_q      <= '0;
            k_q      <= '0;
            found_q  <= 1'b0;
            reinit_q <= 1'b0;
            state_q  <= ST_RD_NCNT;
          end
        end
        ST_RD_NCNT: begin
          if (rd_valid) begin
            ncnt_q  <= NCW'(clamp_u(32'(rd_data), MAX_NEIGHBORS));
            state_q <= ST_RD_KCNT;
          end
        end
        ST_RD_KCNT: begin
          if (rd_valid) begin
            kcnt_q  <= KCW'(clamp_u(32'(rd_data), MAX_SINKS));
            state_q <= (ncnt_q == '0) ? ST_INS_CHK : ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (rd_valid) begin
            if (rd_data == bus.fsourceID) begin
              found_q <= 1'b1;
              state_q <= ST_UPD_BATT;
            end else if (32'(n_q) + 1 == 32'(ncnt_q)) begin
              state_q <= ST_INS_CHK;
            end else begin
              n_q <= n_q + NCW'(1);
            end
          end
        end
        ST_UPD_BATT: state_q <= ST_UPD_RDQ;
        ST_UPD_RDQ: begin
          if (rd_valid) begin
            reinit_q <= (rd_data < bus.fValue);
            state_q  <= ST_UPD_WRQ;
          end
        end
        ST_UPD_WRQ: state_q <= ST_UPD_CID;
        ST_INS_CHK: begin
          if (32'(ncnt_q) == MAX_NEIGHBORS) begin
            status_q <= STAT_FULL;
            state_q  <= ST_FIN;
          end else begin
            n_q     <= ncnt_q;
            state_q <= ST_INS_NID;
          end
        end
        ST_INS_NID:  state_q <= ST_INS_BATT;
        ST_INS_BATT: state_q <= ST_INS_QVAL;
        ST_INS_QVAL: state_q <= ST_INS_CID;
        ST_UPD_CID, ST_INS_CID: begin
          // Row offset is fixed for the rest of the operation.
          row_off_q <= AW'(32'(n_q) * ROW_BYTES);
          state_q   <= (kcnt_q == '0) ? ST_SC_CNT : ST_SC_RD;
        end
        ST_SC_RD: begin
          if (rd_valid) begin
            sink_q  <= rd_data;
            state_q <= ST_SC_WR;
          end
        end
        ST_SC_WR: begin
          if (32'(k_q) + 1 == 32'(kcnt_q)) begin
            state_q <= ST_SC_CNT;
          end else begin
            k_q     <= k_q + KCW'(1);
            state_q <= ST_SC_RD;
          end
        end
        ST_SC_CNT: state_q <= ST_POST;
        ST_POST: begin
          status_q <= found_q ? STAT_UPDATED : STAT_INSERTED;
          state_q  <= ST_FIN;
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_seq_port #(
    .DW(DW),
    .AW(AW)
  ) u_port (
    .clk_i      (clock),
    .rst_ni     (nrst),
    .rd_req_i   (rd_req),
    .wr_req_i   (wr_req),
    .addr_i     (req_addr),
    .wdata_i    (req_wdata),
    .data_in_i  (bus.data_in),
    .address_o  (bus.address),
    .data_out_o (bus.data_out),
    .wr_en_o    (bus.wr_en),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/learn_costs_param.md
Name: learn_costs_param

Overview:
- Parametrised successor to the cluster-head cost-learning engine. On each received routing frame it updates or inserts a neighbour entry in the shared node memory: neighbour ID, cluster ID, battery status, Q-value, and the per-neighbour copy of the known-sink list.
- Sits between the frame parser and the byte-addressed node RAM.
- Adds over the previous block: bounded table size, table-full rejection, real Q-value overwrite, sink-count clamping, and a result status code.

Parameters:
- DW, 16, data/word width of all data ports.
- AW, 16, memory address width.
- MAX_NEIGHBORS, 64, neighbour table capacity.
- MAX_SINKS, 8, sink slots per neighbour row. Sink row stride is 2*MAX_SINKS bytes.
- EPS_ADDR, 16'h004, epsilon word.
- KSINK_BASE, 16'h008, known-sink list.
- NID_BASE, 16'h048, neighbour IDs.
- CID_BASE, 16'h0C8, cluster IDs.
- BATT_BASE, 16'h148, battery status.
- QVAL_BASE, 16'h1C8, Q-values.
- SID_BASE, 16'h248, per-neighbour sink rows.
- KSCNT_ADDR, 16'h688, known-sink count.
- NCNT_ADDR, 16'h68A, neighbour count.
- SIDCNT_BASE, 16'h68E, per-neighbour sink counts.

Ports:
- clock  in  1  single clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  start request, sampled only in IDLE.
- fsourceID, fbatteryStat, fValue, fclusterID  in  DW each  frame fields; must be held stable from en until done.
- initial_epsilon  in  DW  epsilon reload value.
- data_in  in  DW  memory read data, valid one cycle after address.
- address  out  AW  memory address.
- data_out  out  DW  memory write data.
- wr_en  out  1  write strobe, single-cycle per word.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle completion pulse.
- status  out  2  result: 0 = updated, 1 = inserted, 2 = table full/rejected; valid with done, held until next accept.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is named clock and the reset port nrst.
- Reset values: address=0, data_out=0, wr_en=0, done=0, busy=0, status=0, state=IDLE, all counters 0. Asserting nrst mid-operation aborts immediately (wr_en drops asynchronously); no partial rollback.
- Memory interface:
  - Word address = base + 2*index.
  - Reads have 1-cycle latency; each read uses an ADDR cycle followed by a CAPTURE cycle.
  - Writes drive address, data_out and wr_en=1 for exactly one cycle. wr_en is never asserted on consecutive words without address/data changing.
- Accept: in IDLE with en=1, the block registers busy=1, clears n, k and flags, and moves to RD_NCNT. en outside IDLE is ignored.
- States:
  - IDLE: wait for en.
  - RD_NCNT: read NCNT_ADDR.
  - RD_KCNT: read KSCNT_ADDR. Clamp neighborCount to MAX_NEIGHBORS and knownSinkCount to MAX_SINKS (clamped value is what gets written back as sink count).
  - SEARCH: for n = 0..neighborCount-1, read NID_BASE+2n and compare to fsourceID. On first match, set found, latch n, go to UPD. After the last entry, go to INS_CHK.
  - UPD:
    - Write BATT_BASE+2n := fbatteryStat.
    - Read QVAL_BASE+2n as oldQ.
    - Write QVAL_BASE+2n := fValue.
    - Write CID_BASE+2n := fclusterID.
    - Set reinit = (oldQ < fValue), unsigned compare.
    - Go to SINKCOPY with row n.
  - INS_CHK: if neighborCount == MAX_NEIGHBORS, status=2, go to FIN with no writes. Otherwise n := neighborCount and go to INS.
  - INS: write NID, BATT, QVAL, CID at index n with fsourceID, fbatteryStat, fValue, fclusterID. Go to SINKCOPY.
  - SINKCOPY: for k = 0..knownSinkCount-1, read KSINK_BASE+2k and write SID_BASE + n*2*MAX_SINKS + 2k. Then write SIDCNT_BASE+2n := knownSinkCount.
  - POST:
    - Insert path: write NCNT_ADDR := neighborCount+1, status=1.
    - Update path: if reinit, write EPS_ADDR := initial_epsilon. status=0.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Boundaries:
  - knownSinkCount=0: only the SIDCNT write (value 0) occurs.
  - Duplicate IDs in the table: first match wins.
  - neighborCount=0: no SEARCH reads.
  - oldQ == fValue: no epsilon write.
- Arithmetic: indices are unsigned. Row offset n*2*MAX_SINKS is computed once per operation into a register, not per sink.

Decomposition:
- Package learn_costs_pkg: state enum, status codes, default base-address constants.
- One natural sub-module, mem_seq_port: ADDR/CAPTURE read sequencing and single-cycle write strobe, shared with future table engines.

Test Plan:
- Empty table (NCNT=0, KSCNT=2, sinks 0x11/0x22), en with fsourceID=5 ->
  - writes: NID[0]=5, BATT, QVAL, CID, SID row0 = 0x11, 0x22, SIDCNT[0]=2, NCNT=1;
  - status=1, one done pulse.
- Table holds IDs 3, 5, 9, fsourceID=5, oldQ=0x10, fValue=0x20 ->
  - index 1 updated, QVAL[1]=0x20, EPS_ADDR=initial_epsilon, NCNT unchanged, status=0.
- Same as above with oldQ=0x30 -> no write to EPS_ADDR, status=0.
- NCNT=64, unknown ID -> zero writes, status=2, done asserted.
- KSCNT=12 in memory -> exactly 8 sinks copied, SIDCNT written as 8.
- nrst pulsed during SINKCOPY -> wr_en/busy/done low immediately; the next en runs cleanly from IDLE.
